// File: rtl/rr_token_arbiter.sv
// ---------------------------------------------------------------------------
// rr_token_arbiter
//
// N-channel round-robin arbiter with a per-channel req/ack handshake in front
// of one shared resource. Idle channels are skipped, so a pending requester
// never waits on an empty slot. An optional hold limit forcibly reclaims the
// grant from a requester that keeps ack high for MAX_HOLD cycles; that
// requester is then masked until it drops req for at least one cycle.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous, active-low reset
//   req       : [N-1:0] request per channel, held high until served
//   ack       : [N-1:0] one-hot (or zero) acknowledge, registered
//   sel       : [IDX_W-1:0] index of the granted channel, registered
//   sel_valid : high while a grant is in progress (READY or BUSY)
//   busy      : high in the BUSY state
//   timeout   : one-cycle pulse when a grant is forcibly reclaimed
// ---------------------------------------------------------------------------
module rr_token_arbiter #(
  parameter  int N        = 3,
  parameter  int MAX_HOLD = 0,
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     ack,
  output logic [IDX_W-1:0] sel,
  output logic             sel_valid,
  output logic             busy,
  output logic             timeout
);

  // Counter is kept at least one bit wide so the design elaborates with the
  // hold limit disabled; in that case it simply saturates and is ignored.
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [N-1:0]        mask_q;
  logic [N-1:0]        ack_q;
  logic                sel_valid_q;
  logic                busy_q;
  logic                timeout_q;

  logic [N-1:0]        elig_d;
  logic [IDX_W-1:0]    pick_d;
  logic                found_d;
  int                  scan_k;
  logic                hold_lim_d;

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin successor of a channel index, wrapping N-1 back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(N - 1)) return '0;
    return idx + 1'b1;
  endfunction

  assign elig_d     = req & ~mask_q;
  assign hold_lim_d = (MAX_HOLD > 0) && (hold_q == HOLD_W'(MAX_HOLD - 1));

  // Scan ptr, ptr+1, ... wrapping mod N; the first eligible channel wins.
  always_comb begin
    found_d = 1'b0;
    pick_d  = '0;
    scan_k  = 0;
    for (int i = 0; i < N; i++) begin
      scan_k = int'(ptr_q) + i;
      if (scan_k >= N) scan_k = scan_k - N;
      if (!found_d && elig_d[scan_k]) begin
        found_d = 1'b1;
        pick_d  = IDX_W'(scan_k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      hold_q      <= '0;
      mask_q      <= '0;
      ack_q       <= '0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      // Any channel seen with req low is released from the mask. A set below
      // only happens with req high, so the two never collide on one bit.
      mask_q    <= mask_q & req;

      case (state_q)
        IDLE: begin
          if (found_d) begin
            gidx_q      <= pick_d;
            sel_valid_q <= 1'b1;
            state_q     <= READY;
          end
        end

        // The grant is committed here regardless of req, so a requester
        // dropping req during READY still sees one cycle of ack.
        READY: begin
          ack_q   <= onehot(gidx_q);
          busy_q  <= 1'b1;
          hold_q  <= '0;
          state_q <= BUSY;
        end

        BUSY: begin
          if (!req[gidx_q] || hold_lim_d) begin
            ack_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ptr_q       <= next_idx(gidx_q);
            state_q     <= IDLE;
            if (req[gidx_q]) begin
              timeout_q      <= 1'b1;
              mask_q[gidx_q] <= 1'b1;
            end
          end else if (hold_q != {HOLD_W{1'b1}}) begin
            hold_q <= hold_q + 1'b1;
          end
        end

        default: begin
          ack_q       <= '0;
          sel_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign sel       = gidx_q;
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_token_arbiter.sv
module tb_rr_token_arbiter;

  localparam int N        = 3;
  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] ack;
  logic [1:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       timeout;

  int n_checks;
  int n_fail;

  rr_token_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ack       (ack),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 3'b000;
    tick();
    tick();
    n_checks++;
    if ({ack, sel, sel_valid, busy, timeout} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_state: got ack=%b sel=%0d sv=%b busy=%b to=%b, expected all zero",
               ack, sel, sel_valid, busy, timeout);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if ({ack, sel_valid, busy, timeout} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got ack=%b sv=%b busy=%b to=%b, expected 0",
                 c, ack, sel_valid, busy, timeout);
      end
    end
  endtask

  // Every master drops req right after seeing its ack and re-raises it on
  // the next cycle; the grant sequence must walk 0,1,2,0,1,2.
  task automatic test_round_robin();
    int exp_order [6] = '{0, 1, 2, 0, 1, 2};
    logic [2:0] oh;
    req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      oh = 3'b001 << exp_order[g];
      tick();
      n_checks++;
      if (sel !== 2'(exp_order[g]) || sel_valid !== 1'b1 || ack !== 3'b000) begin
        n_fail++;
        $display("FAIL rr_grant %0d: got sel=%0d sv=%b ack=%b, expected sel=%0d sv=1 ack=000",
                 g, sel, sel_valid, ack, exp_order[g]);
      end
      tick();
      n_checks++;
      if (ack !== oh || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_ack %0d: got ack=%b busy=%b, expected ack=%b busy=1", g, ack, busy, oh);
      end
      req = req & ~oh;
      tick();
      n_checks++;
      if (ack !== 3'b000 || sel_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_idle_gap %0d: got ack=%b sv=%b busy=%b, expected 000/0/0",
                 g, ack, sel_valid, busy);
      end
      req = 3'b111;
    end
    req = 3'b000;
  endtask

  // Single requester latency, then the pointer moves past channel 0 so a
  // 3'b101 request is served channel 2 first.
  task automatic test_latency_and_ptr();
    req = 3'b001;
    tick();
    n_checks++;
    if (sel !== 2'd0 || sel_valid !== 1'b1 || ack !== 3'b000) begin
      n_fail++;
      $display("FAIL lat_sel: got sel=%0d sv=%b ack=%b, expected 0/1/000", sel, sel_valid, ack);
    end
    tick();
    n_checks++;
    if (ack !== 3'b001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_ack: got ack=%b busy=%b, expected 001/1", ack, busy);
    end
    tick();
    tick();
    n_checks++;
    if (ack !== 3'b001 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_hold: got ack=%b to=%b, expected 001/0", ack, timeout);
    end
    req = 3'b000;
    tick();
    n_checks++;
    if (ack !== 3'b000 || sel_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_release: got ack=%b sv=%b busy=%b, expected 000/0/0", ack, sel_valid, busy);
    end
    n_checks++;
    if (sel !== 2'd0) begin
      n_fail++;
      $display("FAIL sel_hold: got sel=%0d, expected 0", sel);
    end
    req = 3'b101;
    tick();
    n_checks++;
    if (sel !== 2'd2 || sel_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ptr_skip: got sel=%0d sv=%b, expected 2/1", sel, sel_valid);
    end
    tick();
    n_checks++;
    if (ack !== 3'b100) begin
      n_fail++;
      $display("FAIL ptr_ack2: got ack=%b, expected 100", ack);
    end
    req = 3'b001;
    tick();
    tick();
    n_checks++;
    if (sel !== 2'd0 || sel_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ptr_wrap: got sel=%0d sv=%b, expected 0/1", sel, sel_valid);
    end
    tick();
    req = 3'b000;
    tick();
    tick();
  endtask

  // Channel 1 holds req forever; after 4 cycles of ack the grant is taken
  // back, channel 2 is served, and channel 1 stays masked until it drops req.
  task automatic test_timeout();
    req = 3'b110;
    tick();
    n_checks++;
    if (sel !== 2'd1 || sel_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL to_grant: got sel=%0d sv=%b, expected 1/1", sel, sel_valid);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (ack !== 3'b010 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL to_hold cycle %0d: got ack=%b to=%b, expected 010/0", c, ack, timeout);
      end
    end
    tick();
    n_checks++;
    if (ack !== 3'b000 || timeout !== 1'b1 || sel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL to_pulse: got ack=%b to=%b sv=%b, expected 000/1/0", ack, timeout, sel_valid);
    end
    tick();
    n_checks++;
    if (timeout !== 1'b0 || sel !== 2'd2 || sel_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL to_next: got to=%b sel=%0d sv=%b, expected 0/2/1", timeout, sel, sel_valid);
    end
    tick();
    n_checks++;
    if (ack !== 3'b100) begin
      n_fail++;
      $display("FAIL to_ack2: got ack=%b, expected 100", ack);
    end
    req = 3'b010;
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (sel_valid !== 1'b0 || ack !== 3'b000) begin
        n_fail++;
        $display("FAIL to_masked cycle %0d: got sv=%b ack=%b, expected 0/000", c, sel_valid, ack);
      end
    end
    req = 3'b000;
    tick();
    req = 3'b010;
    tick();
    n_checks++;
    if (sel !== 2'd1 || sel_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL to_unmask: got sel=%0d sv=%b, expected 1/1", sel, sel_valid);
    end
    tick();
    req = 3'b000;
    tick();
    tick();
  endtask

  // Asynchronous reset mid-BUSY, then the scan restarts at channel 0.
  task automatic test_async_reset();
    req = 3'b010;
    tick();
    tick();
    n_checks++;
    if (ack !== 3'b010 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_pre: got ack=%b busy=%b, expected 010/1", ack, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ack !== 3'b000 || sel_valid !== 1'b0 || busy !== 1'b0 || sel !== 2'd0) begin
      n_fail++;
      $display("FAIL ar_immediate: got ack=%b sv=%b busy=%b sel=%0d, expected 000/0/0/0",
               ack, sel_valid, busy, sel);
    end
    req = 3'b110;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (sel !== 2'd1 || sel_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_first: got sel=%0d sv=%b, expected 1/1", sel, sel_valid);
    end
    tick();
    n_checks++;
    if (ack !== 3'b010) begin
      n_fail++;
      $display("FAIL ar_ack: got ack=%b, expected 010", ack);
    end
    req = 3'b000;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 3'b000;
    test_reset();
    test_round_robin();
    test_latency_and_ptr();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
